pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised successor to the single enable/clear register.
- An elastic chain of DEPTH data registers, each BITS wide, with a valid/ready handshake at both ends.
- Empty stages collapse bubbles. Global stall (en) and synchronous flush (clear) are supported.
- Used as the stage-balancing pipeline in the iterative sqrt/divide datapaths and between core pipeline units where backpressure exists.

Parameters:
- BITS, 32, payload width per stage (>=1).
- DEPTH, 2, number of register stages (1..16). Values outside this range cause an elaboration error via $error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous flush of all stages.
- en  input  1  global advance enable; 0 = freeze the whole chain.
- in_valid  input  1  upstream beat present.
- in_data  input  BITS  upstream payload.
- in_ready  output  1  chain accepts a beat this cycle.
- out_valid  output  1  stage DEPTH-1 holds a beat.
- out_data  output  BITS  stage DEPTH-1 payload.
- out_ready  input  1  downstream accepts.
- count  output  $clog2(DEPTH+2)  number of beats currently held, including the skid entry when that feature is built.

Behaviour:
- **State:** per stage i, valid_q[i] and data_q[i].
- **Reset:** rst=1 forces every valid_q, every data_q and the skid to 0. Resulting outputs: out_valid=0, out_data=0, count=0, in_ready=0 during the reset cycle.
- **Priority:** rst > clear > en > normal advance.
- **clear=1:**
  - All valid_q and data_q are zeroed next cycle.
  - in_ready is forced to 0 in the same cycle; any in_valid beat is dropped.
  - out_valid still reflects the current register, but a handshake that cycle is ignored (no pop is counted).
- **en=0:**
  - Every register holds.
  - in_ready=0 in that cycle.
  - out_valid and out_data stay stable, and the downstream handshake does not pop.
- **Ready chain, with en=1 and clear=0:**
  - r[DEPTH] = out_ready.
  - r[i] = !valid_q[i] | r[i+1].
  - in_ready = r[0].
  - The chain is combinational from out_ready to in_ready.
- **Stage load:**
  - Stage i loads when r[i]=1.
  - Stage 0 takes in_data and valid_q[0] <= in_valid.
  - Stage i>0 takes data_q[i-1] and valid_q[i] <= valid_q[i-1].
  - When a stage loads from an invalid source, its data is don't-care but must not X-propagate; zero or hold are both acceptable.
- **Stage hold:** when r[i]=0, stage i holds.
- **Latency:**
  - An accepted beat appears at out_valid exactly DEPTH cycles after acceptance when the chain never stalls.
  - Sustained throughput is 1 beat/cycle with out_ready=1.
- **Ordering:** beats are never reordered, duplicated or lost, except through clear or rst.
- **Full chain:** in_ready = out_ready combinationally.
  - A simultaneous push and pop keeps count constant.
- **Empty chain:** in_ready=1 regardless of out_ready.
- **count:** increments on push-only, decrements on pop-only, and is unchanged when push and pop coincide.
- **Mid-operation flush:** a reset or clear mid-operation leaves no residual beats; count returns to 0 next cycle.

Optional Feature:
- Macro: PIPE_REG_CHAIN_SKID_EN.
- **Defined:** a one-entry skid register sits before stage 0.
  - in_ready is a flop output equal to "skid empty", which breaks the combinational path from out_ready.
  - A beat arriving while stage 0 cannot load is stored in the skid.
  - Stage 0 sources from the skid first whenever the skid is occupied.
  - Latency is unchanged (DEPTH cycles) when the skid is not in use.
  - count includes the skid entry, so its maximum is DEPTH+1.
  - clear and rst empty the skid.
- **Undefined:** the behaviour is exactly as described in Behaviour above, and count never exceeds DEPTH.

Decomposition:
- Package pipe_reg_pkg holds:
  - a localparam function for count width, cnt_w(depth) = $clog2(depth+2);
  - a typedef for the per-stage record, a struct containing valid and data, parameterised via a width-generic packing helper.
- Natural sub-module: pipe_reg_stage, one valid+data register with load, hold, clear and reset, instantiated DEPTH times in a generate loop.

Test Plan:
1. **Reset and latency:** BITS=32, DEPTH=3. Hold rst for 2 cycles, then push 0xA5A5_0001 with out_ready=1.
   - During reset: out_valid=0, count=0.
   - The beat appears at out_valid exactly 3 cycles after acceptance.
2. **Full then stall:** DEPTH=3, out_ready=0. Push 0x1, 0x2, 0x3, 0x4.
   - The first three are accepted; in_ready=0 for the fourth; count=3.
   - Then raise out_ready with in_valid=1: in_ready=1 in the same cycle, and out_data order is 1, 2, 3.
3. **Bubble collapse:** DEPTH=4. Push one beat, hold out_ready=0 for 6 cycles, then push a second beat.
   - Both beats are adjacent at stages 3 and 2; count=2; in_ready stays 1.
4. **Flush:** chain holds 2 beats. Assert clear with in_valid=1 and out_ready=1.
   - in_ready=0; the beat is dropped; no pop is counted.
   - Next cycle: out_valid=0, count=0.
5. **Stall via en:** chain holds 0x7. Drop en for 3 cycles with out_ready=1.
   - out_data stays 0x7; no pop; count unchanged.
   - Restore en: the pop occurs.
6. **With PIPE_REG_CHAIN_SKID_EN:** DEPTH=2, full chain, out_ready=0, push 0x9.
   - The skid takes it; count=3.
   - Next cycle in_ready=0 (registered).
   - Release out_ready: order is preserved, and in_ready returns to 1 one cycle after the skid drains.

Source files
------------

// File: rtl/pipe_reg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_reg_pkg: shared sizing helpers and stage record for pipe_reg_chain. Rev 1.0
// ----------------------------------------------------------------------------
package pipe_reg_pkg;

   localparam int MIN_DEPTH = 1;
   localparam int MAX_DEPTH = 16;
   localparam int MAX_BITS  = 1024;

   // Width of a beat counter able to report 0..depth+1 (skid entry included).
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 2);
   endfunction

   typedef struct packed {
      logic                valid;
      logic [MAX_BITS-1:0] data;
   } stage_rec_t;

   function automatic stage_rec_t pack_rec(input logic valid, input logic [MAX_BITS-1:0] data);
      stage_rec_t rec;
      rec.valid = valid;
      rec.data  = data;
      return rec;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_reg_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_reg_stage: one valid+data register with load, hold, flush and reset. Rev 1.0
// ----------------------------------------------------------------------------
module pipe_reg_stage #(
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            load,
   input  logic            src_valid,
   input  logic [BITS-1:0] src_data,
   output logic            valid,
   output logic [BITS-1:0] data
);

   logic            r_valid;
   logic [BITS-1:0] r_data;

   // Payload only follows a valid source, so bubbles never carry X into the chain.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (load) begin
         r_valid <= src_valid;
         if (src_valid) begin
            r_data <= src_data;
         end
      end
   end

   assign valid = r_valid;
   assign data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_reg_chain: elastic DEPTH-stage valid/ready register chain with bubble
// collapse; optional input skid register via PIPE_REG_CHAIN_SKID_EN. Rev 1.0
// ----------------------------------------------------------------------------
module pipe_reg_chain
   import pipe_reg_pkg::*;
#(
   parameter int BITS  = 32,
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      en,
   input  logic                      in_valid,
   input  logic [BITS-1:0]           in_data,
   output logic                      in_ready,
   output logic                      out_valid,
   output logic [BITS-1:0]           out_data,
   input  logic                      out_ready,
   output logic [cnt_w(DEPTH)-1:0]   count
);

   localparam int CNT_W = cnt_w(DEPTH);

   if (DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH) begin : g_bad_depth
      $error("pipe_reg_chain: DEPTH=%0d outside 1..16", DEPTH);
   end
   if (BITS < 1) begin : g_bad_bits
      $error("pipe_reg_chain: BITS must be >= 1");
   end

   logic             w_adv;
   logic [DEPTH-1:0] w_valid;
   logic [BITS-1:0]  w_data [DEPTH];
   logic [DEPTH:0]   w_rdy;
   logic             w_src_valid;
   logic [BITS-1:0]  w_src_data;
   logic             w_extra;
   logic [CNT_W-1:0] w_cnt;

   assign w_adv = en & ~clear & ~rst;

   // Ready ripples from the sink back to the source; an empty stage always accepts.
   always_comb begin
      w_rdy        = '0;
      w_rdy[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         w_rdy[i] = ~w_valid[i] | w_rdy[i+1];
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic            w_sv;
      logic [BITS-1:0] w_sd;
      if (i == 0) begin : g_head
         assign w_sv = w_src_valid;
         assign w_sd = w_src_data;
      end else begin : g_body
         assign w_sv = w_valid[i-1];
         assign w_sd = w_data[i-1];
      end
      pipe_reg_stage #(.BITS(BITS)) u_stage (
         .clk       (clk),
         .rst       (rst),
         .clear     (clear),
         .load      (w_adv & w_rdy[i]),
         .src_valid (w_sv),
         .src_data  (w_sd),
         .valid     (w_valid[i]),
         .data      (w_data[i])
      );
   end

`ifdef PIPE_REG_CHAIN_SKID_EN
   logic            r_skid_valid;
   logic [BITS-1:0] r_skid_data;

   // The skid catches a beat accepted while stage 0 is blocked and feeds stage 0 first.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
      end else if (w_adv) begin
         if (r_skid_valid) begin
            if (w_rdy[0]) begin
               r_skid_valid <= 1'b0;
            end
         end else if (in_valid && !w_rdy[0]) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
         end
      end
   end

   assign w_src_valid = r_skid_valid | in_valid;
   assign w_src_data  = r_skid_valid ? r_skid_data : in_data;
   assign in_ready    = w_adv & ~r_skid_valid;
   assign w_extra     = r_skid_valid;
`else
   assign w_src_valid = in_valid;
   assign w_src_data  = in_data;
   assign in_ready    = w_adv & w_rdy[0];
   assign w_extra     = 1'b0;
`endif

   always_comb begin
      w_cnt = CNT_W'(w_extra);
      for (int i = 0; i < DEPTH; i++) begin
         w_cnt = w_cnt + CNT_W'(w_valid[i]);
      end
   end

   assign count     = rst ? '0 : w_cnt;
   assign out_valid = w_valid[DEPTH-1] & ~rst;
   assign out_data  = rst ? '0 : w_data[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_reg_chain: directed + random stimulus against a beat-position model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_pipe_reg_chain;

   localparam int BITS  = 32;
   localparam int DEPTH = 3;
   localparam int CW    = $clog2(DEPTH + 2);
`ifdef PIPE_REG_CHAIN_SKID_EN
   localparam int SKID = 1;
`else
   localparam int SKID = 0;
`endif

   logic            clk = 1'b0;
   logic            rst, clear, en, in_valid, out_ready;
   logic [BITS-1:0] in_data;
   logic            in_ready, out_valid;
   logic [BITS-1:0] out_data;
   logic [CW-1:0]   count;

   int n_cmp = 0;
   int n_err = 0;

   // Model: beats in order, oldest first, with their stage index (-1 = skid).
   int              q_pos[$];
   logic [BITS-1:0] q_dat[$];

   pipe_reg_chain #(.BITS(BITS), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .en        (en),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Lowest stage still free after every held beat advances as far as it can.
   function automatic int free_limit(input bit do_pop);
      int lim = DEPTH - 1;
      int np;
      for (int k = 0; k < q_pos.size(); k++) begin
         if (k == 0 && do_pop && q_pos[0] == DEPTH - 1) continue;
         np  = (q_pos[k] + 1 < lim) ? q_pos[k] + 1 : lim;
         lim = np - 1;
      end
      return lim;
   endfunction

   task automatic step(input logic r, input logic c, input logic e, input logic iv,
                       input logic [BITS-1:0] d, input logic ordy);
      bit adv, exp_ov, pop, skid_busy, exp_ir;
      int lim, np;
      int              n_pos[$];
      logic [BITS-1:0] n_dat[$];
      rst = r; clear = c; en = e; in_valid = iv; in_data = d; out_ready = ordy;
      @(negedge clk);
      adv       = e && !c && !r;
      exp_ov    = !r && q_pos.size() > 0 && q_pos[0] == DEPTH - 1;
      pop       = adv && exp_ov && ordy;
      lim       = free_limit(pop);
      skid_busy = q_pos.size() > 0 && q_pos[q_pos.size()-1] == -1;
      exp_ir    = adv && ((SKID != 0) ? !skid_busy : (lim >= 0));
      check_val("out_valid", 64'(out_valid), 64'(exp_ov));
      check_val("in_ready", 64'(in_ready), 64'(exp_ir));
      check_val("count", 64'(count), r ? 64'd0 : 64'(q_pos.size()));
      if (exp_ov) check_val("out_data", 64'(out_data), 64'(q_dat[0]));
      if (r) check_val("rst_out_data", 64'(out_data), 64'd0);
      @(posedge clk);
      if (r || c) begin
         q_pos.delete();
         q_dat.delete();
      end else if (adv) begin
         lim = DEPTH - 1;
         for (int k = 0; k < q_pos.size(); k++) begin
            if (k == 0 && pop) continue;
            np  = (q_pos[k] + 1 < lim) ? q_pos[k] + 1 : lim;
            lim = np - 1;
            n_pos.push_back(np);
            n_dat.push_back(q_dat[k]);
         end
         if (iv && exp_ir) begin
            n_pos.push_back((lim < 0) ? -1 : 0);
            n_dat.push_back(d);
         end
         q_pos = n_pos;
         q_dat = n_dat;
      end
      #1;
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1, 1'b0, '0, ordy);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // Reset, then first-beat latency
      step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 1'b1);
      for (int j = 1; j < DEPTH; j++) begin
         check_val("lat_early", 64'(out_valid), 64'd0);
         step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
      end
      check_val("lat_hit", 64'(out_valid), 64'd1);
      check_val("lat_data", 64'(out_data), 64'hA5A5_0001);
      idle(2, 1'b1);

      // Fill against a blocked sink, then release while still pushing
      for (int v = 1; v <= 4; v++) step(1'b0, 1'b0, 1'b1, 1'b1, BITS'(v), 1'b0);
      check_val("full_cnt", 64'(count), 64'(DEPTH + SKID));
      for (int v = 5; v <= 7; v++) step(1'b0, 1'b0, 1'b1, 1'b1, BITS'(v), 1'b1);
      idle(DEPTH + 3, 1'b1);

      // Bubble collapse
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_00B1, 1'b0);
      idle(6, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_00B2, 1'b0);
      check_val("bubble_cnt", 64'(count), 64'd2);
      idle(DEPTH + 2, 1'b1);

      // Flush with a live handshake on both sides
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h22, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h33, 1'b1);
      check_val("flush_cnt", 64'(count), 64'd0);
      check_val("flush_ov", 64'(out_valid), 64'd0);

      // Stall via en with a beat waiting at the output
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h7, 1'b0);
      idle(DEPTH, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 1'b1);
      check_val("stall_data", 64'(out_data), 64'h7);
      step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
      check_val("stall_pop_cnt", 64'(count), 64'd0);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         step(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 3),
              ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 60),
              BITS'($urandom), ($urandom_range(0, 99) < 55));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
